// File: rtl/program_counter_unit_if.sv
// Fetch-side bundle for program_counter_unit: redirect requests and holds in, PC and RAS status out.
// The master is the decode/control side and the slave is the PC unit.
interface program_counter_unit_if #(
    parameter int ADDR_W = 16
);
    logic              halt_sys;
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              jump;
    logic              call;
    logic [ADDR_W-1:0] jump_target;
    logic              ret;
    logic [ADDR_W-1:0] ret_address;
    logic [ADDR_W-1:0] out_address;
    logic [ADDR_W-1:0] next_address;
    logic              redirect_pending;
    logic              ras_empty;
    logic              ras_full;

    modport master (
        output halt_sys, stall, branch_taken, branch_target, jump, call,
               jump_target, ret, ret_address,
        input  out_address, next_address, redirect_pending, ras_empty, ras_full
    );

    modport slave (
        input  halt_sys, stall, branch_taken, branch_target, jump, call,
               jump_target, ret, ret_address,
        output out_address, next_address, redirect_pending, ras_empty, ras_full
    );
endinterface

// File: rtl/program_counter_unit.sv
// Program counter with next-PC selection, a pending-redirect register for holds, and an
// optional circular return-address stack built only when PC_RAS_EN is defined.
module program_counter_unit #(
    parameter int ADDR_W     = 16,
    parameter int INC        = 2,
    parameter int RESET_ADDR = 0,
    parameter int RAS_DEPTH  = 4
) (
    input logic                   clk,
    input logic                   rst,
    program_counter_unit_if.slave bus
);

    generate
        if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_ras_depth
            $error("RAS_DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic              hold;
    logic              live;
    logic [ADDR_W-1:0] seq_address;
    logic [ADDR_W-1:0] ret_target;
    logic [ADDR_W-1:0] live_target;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pending_target_reg;
    logic              pending_reg;

    assign hold        = bus.halt_sys | bus.stall;
    assign live        = bus.ret | bus.call | bus.jump | bus.branch_taken;
    assign seq_address = pc_reg + ADDR_W'(INC);

`ifdef PC_RAS_EN
    localparam int              PTR_W     = $clog2(RAS_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(RAS_DEPTH);

    // sp_reg points at the next free slot; when full it also points at the oldest entry,
    // so a push while full overwrites the oldest return address.
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  sp_reg;
    logic [PTR_W:0]    count_reg;
    logic              push;
    logic              pop;

    assign pop        = bus.ret && (count_reg != '0);
    assign push       = bus.call && !bus.ret;
    assign ret_target = (count_reg != '0) ? ras_mem[sp_reg - PTR_ONE] : bus.ret_address;

    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[sp_reg] <= seq_address;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_reg    <= '0;
            count_reg <= '0;
        end else if (pop) begin
            sp_reg    <= sp_reg - PTR_ONE;
            count_reg <= count_reg - 1'b1;
        end else if (push) begin
            sp_reg <= sp_reg + PTR_ONE;
            if (count_reg != DEPTH_CNT) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign bus.ras_empty = (count_reg == '0);
    assign bus.ras_full  = (count_reg == DEPTH_CNT);
`else
    assign ret_target    = bus.ret_address;
    assign bus.ras_empty = 1'b1;
    assign bus.ras_full  = 1'b0;
`endif

    // Priority ret > call > jump > branch; lower requests in the same cycle are dropped.
    always_comb begin
        live_target = bus.branch_target;
        if (bus.ret) begin
            live_target = ret_target;
        end else if (bus.call || bus.jump) begin
            live_target = bus.jump_target;
        end
    end

    always_comb begin
        next_pc = seq_address;
        if (hold) begin
            next_pc = pc_reg;
        end else if (live) begin
            next_pc = live_target;
        end else if (pending_reg) begin
            next_pc = pending_target_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg             <= ADDR_W'(RESET_ADDR);
            pending_reg        <= 1'b0;
            pending_target_reg <= '0;
        end else begin
            pc_reg <= next_pc;
            if (hold && live) begin
                pending_reg        <= 1'b1;
                pending_target_reg <= live_target;
            end else if (!hold) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign bus.out_address      = pc_reg;
    assign bus.next_address     = next_pc;
    assign bus.redirect_pending = pending_reg;

endmodule
